// File: rtl/uart_rx_pkg.sv
// Shared constants and state encodings for the 8N1 UART receiver.
package uart_rx_pkg;

  // i_clk cycles per bit at 12 MHz / 115200; the transmitter uses the same value
  localparam int unsigned UART_BIT_CLKS = 104;

  // Width of the bit-timing counter; N_BIT_CLKS must stay within 4..4095
  localparam int unsigned CLK_COUNT_W = 12;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    CLEANUP   = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Generic two-flop synchronizer for an asynchronous pin, resetting to 1 (idle-high lines).
module uart_sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic meta;

  // Two back-to-back flops; reset to 1 so an idle-high line never looks like a falling edge
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      meta <= 1'b1;
      o_q  <= 1'b1;
    end else begin
      meta <= i_d;
      o_q  <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 asynchronous serial receiver: recovers one byte per frame from i_rxd and
// presents it with a one-cycle valid strobe, or a one-cycle frame-error strobe
// when the stop bit is low.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned N_BIT_CLKS = UART_BIT_CLKS
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rxd,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_rx_busy,
  output logic       o_frame_err
);

  // Mid-bit point of the start bit, and the full-bit count used from then on
  localparam logic [CLK_COUNT_W-1:0] HALF_BIT = CLK_COUNT_W'((N_BIT_CLKS - 1) / 2);
  localparam logic [CLK_COUNT_W-1:0] LAST_CLK = CLK_COUNT_W'(N_BIT_CLKS - 1);

  logic                   rxd_s;
  rx_state_t              state;
  logic [CLK_COUNT_W-1:0] clk_count;
  logic [2:0]             bit_index;
  logic [7:0]             shift;

  uart_sync2 u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_rxd),
    .o_q   (rxd_s)
  );

  // Receive FSM: re-centres on the start bit, then samples every data and stop bit at mid-bit
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      clk_count   <= '0;
      bit_index   <= '0;
      shift       <= '0;
      o_rx_data   <= '0;
      o_rx_valid  <= 1'b0;
      o_rx_busy   <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_rx_valid  <= 1'b0;
      o_frame_err <= 1'b0;
      case (state)
        IDLE: begin
          clk_count <= '0;
          bit_index <= '0;
          o_rx_busy <= 1'b0;
          if (!rxd_s) begin
            state     <= START;
            o_rx_busy <= 1'b1;
          end
        end
        START: begin
          if (clk_count == HALF_BIT) begin
            clk_count <= '0;
            if (!rxd_s) begin
              state <= DATA;
            end else begin
              state     <= IDLE;
              o_rx_busy <= 1'b0;
            end
          end else begin
            clk_count <= clk_count + 1'b1;
          end
        end
        DATA: begin
          if (clk_count == LAST_CLK) begin
            clk_count        <= '0;
            shift[bit_index] <= rxd_s;
            if (bit_index == 3'd7) begin
              bit_index <= '0;
              state     <= STOP;
            end else begin
              bit_index <= bit_index + 1'b1;
            end
          end else begin
            clk_count <= clk_count + 1'b1;
          end
        end
        STOP: begin
          if (clk_count == LAST_CLK) begin
            clk_count <= '0;
            if (rxd_s) begin
              o_rx_data  <= shift;
              o_rx_valid <= 1'b1;
              state      <= CLEANUP;
            end else begin
              o_frame_err <= 1'b1;
              state       <= WAIT_HIGH;
            end
          end else begin
            clk_count <= clk_count + 1'b1;
          end
        end
        CLEANUP: begin
          state     <= IDLE;
          o_rx_busy <= 1'b0;
        end
        WAIT_HIGH: begin
          if (rxd_s) begin
            state     <= IDLE;
            o_rx_busy <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          clk_count <= '0;
          bit_index <= '0;
          o_rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx with a 16-clock bit period.
module tb_uart_rx;

  localparam int unsigned BIT_CLKS = 16;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_rxd = 1'b1;
  logic [7:0] o_rx_data;
  logic       o_rx_valid;
  logic       o_rx_busy;
  logic       o_frame_err;

  int         assertCount = 0;
  int         failCount = 0;
  int         validCount = 0;
  int         errCount = 0;
  int         overlapCount = 0;
  logic [7:0] dataLog [0:15];

  uart_rx #(.N_BIT_CLKS(BIT_CLKS)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_rxd       (i_rxd),
    .o_rx_data   (o_rx_data),
    .o_rx_valid  (o_rx_valid),
    .o_rx_busy   (o_rx_busy),
    .o_frame_err (o_frame_err)
  );

  // 10 ns system clock
  always #5 i_clk = ~i_clk;

  // Pulse monitor sampled mid-cycle: logs every valid byte and counts error pulses
  always @(negedge i_clk) begin
    if (o_rx_valid) begin
      if (validCount < 16) dataLog[validCount] = o_rx_data;
      validCount = validCount + 1;
    end
    if (o_frame_err) errCount = errCount + 1;
    if (o_rx_valid && o_frame_err) overlapCount = overlapCount + 1;
  end

  task automatic waitClks(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount = assertCount + 1;
    assert (observed === expected) else begin
      failCount = failCount + 1;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives one 8N1 frame; period10 is the bit period in tenths of a clock (160 = nominal)
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit,
                               input int period10);
    logic [9:0] frame;
    int         startEdge;
    int         endEdge;
    frame = {stopBit, data, 1'b0};
    for (int k = 0; k < 10; k++) begin
      startEdge = (k * period10 + 5) / 10;
      endEdge   = ((k + 1) * period10 + 5) / 10;
      i_rxd = frame[k];
      waitClks(endEdge - startEdge);
    end
  endtask

  initial begin
    $display("[TB] uart_rx bench start");

    i_rst = 1'b1;
    #1;
    checkOutput("reset_data", 32'(o_rx_data), 32'h00);
    checkOutput("reset_valid", 32'(o_rx_valid), 32'h0);
    checkOutput("reset_busy", 32'(o_rx_busy), 32'h0);
    checkOutput("reset_err", 32'(o_frame_err), 32'h0);
    waitClks(3);
    i_rst = 1'b0;
    waitClks(4);

    applyStimulus(8'hA5, 1'b1, 160);
    waitClks(4);
    checkOutput("a5_valid_count", 32'(validCount), 32'd1);
    checkOutput("a5_log", 32'(dataLog[0]), 32'hA5);
    checkOutput("a5_data", 32'(o_rx_data), 32'hA5);
    checkOutput("a5_err_count", 32'(errCount), 32'd0);
    checkOutput("a5_busy_after", 32'(o_rx_busy), 32'h0);

    applyStimulus(8'h00, 1'b1, 160);
    applyStimulus(8'hFF, 1'b1, 160);
    waitClks(4);
    checkOutput("b2b_valid_count", 32'(validCount), 32'd3);
    checkOutput("b2b_first", 32'(dataLog[1]), 32'h00);
    checkOutput("b2b_second", 32'(dataLog[2]), 32'hFF);
    checkOutput("b2b_data", 32'(o_rx_data), 32'hFF);

    waitClks(8);
    i_rxd = 1'b0;
    waitClks(4);
    i_rxd = 1'b1;
    waitClks(1);
    checkOutput("glitch_busy_seen", 32'(o_rx_busy), 32'h1);
    waitClks(8);
    checkOutput("glitch_busy_clear", 32'(o_rx_busy), 32'h0);
    waitClks(8);
    checkOutput("glitch_no_valid", 32'(validCount), 32'd3);
    checkOutput("glitch_data_held", 32'(o_rx_data), 32'hFF);

    applyStimulus(8'h3C, 1'b0, 160);
    waitClks(40 * BIT_CLKS);
    checkOutput("break_err_count", 32'(errCount), 32'd1);
    checkOutput("break_no_valid", 32'(validCount), 32'd3);
    checkOutput("break_data_held", 32'(o_rx_data), 32'hFF);
    checkOutput("break_busy", 32'(o_rx_busy), 32'h1);
    i_rxd = 1'b1;
    waitClks(2 * BIT_CLKS);
    checkOutput("break_busy_clear", 32'(o_rx_busy), 32'h0);
    applyStimulus(8'h5A, 1'b1, 160);
    waitClks(4);
    checkOutput("after_break_valid", 32'(validCount), 32'd4);
    checkOutput("after_break_data", 32'(o_rx_data), 32'h5A);
    checkOutput("after_break_err", 32'(errCount), 32'd1);

    i_rxd = 1'b0;
    waitClks(BIT_CLKS);
    for (int k = 0; k < 4; k++) begin
      i_rxd = (k == 0) ? 1'b1 : 1'b0;
      waitClks(BIT_CLKS);
    end
    i_rxd = 1'b0;
    waitClks(BIT_CLKS / 2);
    i_rst = 1'b1;
    i_rxd = 1'b1;
    #1;
    checkOutput("midreset_data", 32'(o_rx_data), 32'h00);
    checkOutput("midreset_busy", 32'(o_rx_busy), 32'h0);
    checkOutput("midreset_valid", 32'(o_rx_valid), 32'h0);
    waitClks(1);
    i_rst = 1'b0;
    waitClks(12 * BIT_CLKS);
    checkOutput("midreset_no_valid", 32'(validCount), 32'd4);
    checkOutput("midreset_no_err", 32'(errCount), 32'd1);
    checkOutput("midreset_idle", 32'(o_rx_busy), 32'h0);
    applyStimulus(8'h42, 1'b1, 160);
    waitClks(4);
    checkOutput("post_reset_valid", 32'(validCount), 32'd5);
    checkOutput("post_reset_data", 32'(o_rx_data), 32'h42);

    waitClks(8);
    applyStimulus(8'h55, 1'b1, 165);
    waitClks(4);
    checkOutput("slow_valid", 32'(validCount), 32'd6);
    checkOutput("slow_data", 32'(o_rx_data), 32'h55);
    checkOutput("slow_err", 32'(errCount), 32'd1);

    i_rst = 1'b1;
    waitClks(1);
    i_rst = 1'b0;
    waitClks(8);
    checkOutput("fast_pre_data", 32'(o_rx_data), 32'h00);
    applyStimulus(8'h55, 1'b1, 155);
    waitClks(4);
    checkOutput("fast_valid", 32'(validCount), 32'd7);
    checkOutput("fast_data", 32'(o_rx_data), 32'h55);
    checkOutput("fast_err", 32'(errCount), 32'd1);

    checkOutput("valid_err_overlap", 32'(overlapCount), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
